// File: rtl/conv2_pkg.sv
// Shared constants, state encoding and tap-geometry helpers for the conv2 sequencer.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package conv2_pkg;

  // Default layer geometry.
  localparam int C2_IN_W  = 12;
  localparam int C2_IN_H  = 12;
  localparam int C2_K     = 5;
  localparam int C2_TAPS  = C2_K * C2_K;
  localparam int C2_OUT_W = C2_IN_W - C2_K + 1;
  localparam int C2_OUT_H = C2_IN_H - C2_K + 1;

  // Sequencer states; plain constants so the encoding matches older netlists.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TAP   = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Kernel row of tap t (taps are numbered row-major across the window).
  function automatic int tap_ky(input int t, input int k);
    return t / k;
  endfunction

  // Kernel column of tap t.
  function automatic int tap_kx(input int t, input int k);
    return t % k;
  endfunction

endpackage

// File: rtl/conv2_win_addr.sv
// Window walker: kernel ky/kx and output row/col counters with an incrementally built read address.
// Latency: address and flags are registered and update on the edge after step/pixel_adv/clear.
// Backpressure: holds everything while neither step, pixel_adv nor clear is asserted.
module conv2_win_addr
  import conv2_pkg::*;
#(
  parameter int IN_W   = C2_IN_W,
  parameter int K      = C2_K,
  parameter int OUT_W  = C2_OUT_W,
  parameter int OUT_H  = C2_OUT_H,
  parameter int FM_AW  = 8,
  parameter int OUT_AW = 6
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              step,
  input  logic              pixel_adv,
  input  logic              clear,
  output logic [FM_AW-1:0]  fm_rd_addr,
  output logic [OUT_AW-1:0] out_addr,
  output logic              first_tap,
  output logic              last_tap,
  output logic              last_pixel
);

  localparam int KW = $clog2(K);
  localparam int CW = $clog2(OUT_W);
  localparam int RW = $clog2(OUT_H);

  localparam logic [KW-1:0] KX_LAST = KW'(tap_kx(K * K - 1, K));
  localparam logic [KW-1:0] KY_LAST = KW'(tap_ky(K * K - 1, K));
  localparam logic [CW-1:0] C_LAST  = CW'(OUT_W - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(OUT_H - 1);

  // From the last column of one kernel row to the first column of the next.
  localparam logic [FM_AW-1:0] KROW_STEP = FM_AW'(IN_W - K + 1);
  // From the last output column of one row to the first column of the next row.
  localparam logic [FM_AW-1:0] PROW_STEP = FM_AW'(K);

  logic [KW-1:0]     ky, kx;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [FM_AW-1:0]  base;   // r*IN_W + c, address of tap 0 of the current pixel
  logic [FM_AW-1:0]  addr;
  logic [OUT_AW-1:0] oidx;

  // Advance the tap walk on each step and the pixel walk on each accepted pixel.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ky   <= '0;
      kx   <= '0;
      col  <= '0;
      row  <= '0;
      base <= '0;
      addr <= '0;
      oidx <= '0;
    end else if (clear) begin
      ky   <= '0;
      kx   <= '0;
      col  <= '0;
      row  <= '0;
      base <= '0;
      addr <= '0;
      oidx <= '0;
    end else if (pixel_adv) begin
      ky   <= '0;
      kx   <= '0;
      oidx <= oidx + 1'b1;
      if (col == C_LAST) begin
        col  <= '0;
        row  <= row + 1'b1;
        base <= base + PROW_STEP;
        addr <= base + PROW_STEP;
      end else begin
        col  <= col + 1'b1;
        base <= base + 1'b1;
        addr <= base + 1'b1;
      end
    end else if (step) begin
      if (kx != KX_LAST) begin
        kx   <= kx + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        kx <= '0;
        if (ky != KY_LAST) begin
          ky   <= ky + 1'b1;
          addr <= addr + KROW_STEP;
        end else begin
          // Window complete; park on tap 0 of the same pixel until it is emitted.
          ky   <= '0;
          addr <= base;
        end
      end
    end
  end

  assign fm_rd_addr = addr;
  assign out_addr   = oidx;
  assign first_tap  = (ky == '0) && (kx == '0);
  assign last_tap   = (ky == KY_LAST) && (kx == KX_LAST);
  assign last_pixel = (row == R_LAST) && (col == C_LAST);

endmodule

// File: rtl/conv2_seq_ctrl.sv
// conv2 layer sequencer: 25 tap steps per output pixel, MAC drain, then valid/ready hand-off.
// Latency: 25 + MAC_LAT + 1 cycles per pixel without stalls; DONE follows the last accepted pixel.
// Backpressure: fm_valid low freezes the tap walk; out_ready low holds out_valid/out_addr in EMIT.
module conv2_seq_ctrl
  import conv2_pkg::*;
#(
  parameter int IN_W    = C2_IN_W,
  parameter int IN_H    = C2_IN_H,
  parameter int K       = C2_K,
  parameter int MAC_LAT = 2,
  parameter int FM_AW   = 8,
  parameter int OUT_AW  = 6
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              go,
  input  logic              fm_valid,
  output logic              fm_rd_en,
  output logic [FM_AW-1:0]  fm_rd_addr,
  output logic              kern_start,
  output logic              kern_ready,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  output logic [OUT_AW-1:0] out_addr,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = IN_W - K + 1;
  localparam int OUT_H = IN_H - K + 1;
  localparam int LW    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  logic [2:0]    state, state_nxt;
  logic [LW-1:0] lat_cnt;
  logic          step, xfer, pixel_adv, clear_cnt, lat_last;
  logic          first_tap, last_tap, last_pixel;

  // A tap only counts when the feature-map word is present, keeping the ROM count aligned.
  assign step      = (state == ST_TAP) && fm_valid;
  assign xfer      = (state == ST_EMIT) && out_ready;
  assign pixel_adv = xfer && !last_pixel;
  assign clear_cnt = xfer && last_pixel;
  assign lat_last  = (lat_cnt == LW'(MAC_LAT - 1));

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (go) state_nxt = ST_TAP;
      ST_TAP:   if (step && last_tap) state_nxt = ST_FLUSH;
      ST_FLUSH: if (lat_last) state_nxt = ST_EMIT;
      ST_EMIT:  if (out_ready) state_nxt = last_pixel ? ST_DONE : ST_TAP;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Counts the MAC pipeline drain cycles after the last tap.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                lat_cnt <= '0;
    else if (state != ST_FLUSH)  lat_cnt <= '0;
    else if (lat_last)           lat_cnt <= '0;
    else                         lat_cnt <= lat_cnt + 1'b1;
  end

  conv2_win_addr #(
    .IN_W   (IN_W),
    .K      (K),
    .OUT_W  (OUT_W),
    .OUT_H  (OUT_H),
    .FM_AW  (FM_AW),
    .OUT_AW (OUT_AW)
  ) u_win (
    .clk        (clk),
    .n_reset    (n_reset),
    .step       (step),
    .pixel_adv  (pixel_adv),
    .clear      (clear_cnt),
    .fm_rd_addr (fm_rd_addr),
    .out_addr   (out_addr),
    .first_tap  (first_tap),
    .last_tap   (last_tap),
    .last_pixel (last_pixel)
  );

  // Outputs decode from the state register so reset clears them without waiting for a clock.
  assign kern_start = (state == ST_TAP);
  assign fm_rd_en   = (state == ST_TAP);
  assign kern_ready = step;
  assign acc_en     = step;
  assign acc_clr    = step && first_tap;
  assign out_valid  = (state == ST_EMIT);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Bench for conv2_seq_ctrl: per-cycle reference model plus directed tables and corner sequences.
// Latency: n/a.
// Backpressure: fm_valid and out_ready are driven both directed and randomly.
module tb_conv2_seq_ctrl;
  import conv2_pkg::*;

  localparam int MAC_LAT = 2;
  localparam int NPIX    = C2_OUT_W * C2_OUT_H;

  logic       clk, n_reset, go, fm_valid, out_ready;
  logic       fm_rd_en, kern_start, kern_ready, acc_clr, acc_en, out_valid, busy, done;
  logic [7:0] fm_rd_addr;
  logic [5:0] out_addr;

  conv2_seq_ctrl dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .go         (go),
    .fm_valid   (fm_valid),
    .fm_rd_en   (fm_rd_en),
    .fm_rd_addr (fm_rd_addr),
    .kern_start (kern_start),
    .kern_ready (kern_ready),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       ks, re, kr, ae, clr, ov, bsy, dn;
    logic [7:0] addr;
    logic [5:0] oa;
  } obs_t;

  typedef struct {
    int         cyc;
    logic       ks, kr, clr;
    logic [7:0] addr;
    logic       ov;
    logic [5:0] oa;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;
  int step_total = 0;
  int xfer_total = 0;
  int done_total = 0;
  logic [7:0] last_step_addr = '0;

  // Reference model: progress through the pass in terms of taps consumed and pixels emitted.
  bit m_busy = 0;
  bit m_done = 0;
  int m_steps = 0;
  int m_post  = 0;
  int m_emit  = 0;

  function automatic obs_t get_obs();
    obs_t o;
    o.ks = kern_start; o.re = fm_rd_en; o.kr = kern_ready; o.ae = acc_en;
    o.clr = acc_clr; o.ov = out_valid; o.bsy = busy; o.dn = done;
    o.addr = fm_rd_addr; o.oa = out_addr;
    return o;
  endfunction

  function automatic obs_t model_exp();
    obs_t e;
    int p, t;
    e = '0;
    if (m_busy && m_done) begin
      e.bsy = 1'b1;
      e.dn  = 1'b1;
    end else if (m_busy) begin
      e.bsy = 1'b1;
      p = m_emit;
      t = m_steps - C2_TAPS * p;
      if (t < C2_TAPS) begin
        e.ks = 1'b1; e.re = 1'b1;
        e.kr = fm_valid; e.ae = fm_valid;
        e.clr = fm_valid && (t == 0);
        e.addr = 8'((p / C2_OUT_W + t / C2_K) * C2_IN_W + (p % C2_OUT_W) + (t % C2_K));
      end else if (m_post >= MAC_LAT) begin
        e.ov = 1'b1;
        e.oa = 6'(p);
      end
    end
    return e;
  endfunction

  task automatic model_next();
    int t;
    if (!n_reset) begin
      m_busy = 0; m_done = 0; m_steps = 0; m_post = 0; m_emit = 0;
    end else if (!m_busy) begin
      if (go) begin
        m_busy = 1; m_steps = 0; m_post = 0; m_emit = 0;
      end
    end else if (m_done) begin
      m_busy = 0; m_done = 0;
    end else begin
      t = m_steps - C2_TAPS * m_emit;
      if (t < C2_TAPS) begin
        if (fm_valid) m_steps++;
      end else if (m_post < MAC_LAT) begin
        m_post++;
      end else if (out_ready) begin
        m_emit++;
        m_post = 0;
        if (m_emit == NPIX) m_done = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Settle the current cycle's inputs, then compare every output with the model.
  task automatic sample();
    obs_t a, e;
    #1;
    e = model_exp();
    a = get_obs();
    if (!e.re) begin a.addr = '0; e.addr = '0; end
    if (!e.ov) begin a.oa = '0; e.oa = '0; end
    chk("model_cycle", 32'(a), 32'(e));
  endtask

  // Record handshakes for this cycle, step the model and move to the next cycle.
  task automatic advance();
    #1;
    if (kern_ready) begin step_total++; last_step_addr = fm_rd_addr; end
    if (out_valid && out_ready) xfer_total++;
    if (done) done_total++;
    model_next();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  vec_t vecs[12];
  int   s0, x0, d0, done_at, ov_at;
  bit   seen, hit, found;

  initial begin
    // cyc, kern_start, kern_ready, acc_clr, fm_rd_addr, out_valid, out_addr
    vecs[0]  = '{1,  1'b1, 1'b1, 1'b1, 8'd0,  1'b0, 6'd0};
    vecs[1]  = '{2,  1'b1, 1'b1, 1'b0, 8'd1,  1'b0, 6'd0};
    vecs[2]  = '{5,  1'b1, 1'b1, 1'b0, 8'd4,  1'b0, 6'd0};
    vecs[3]  = '{6,  1'b1, 1'b1, 1'b0, 8'd12, 1'b0, 6'd0};
    vecs[4]  = '{7,  1'b1, 1'b1, 1'b0, 8'd13, 1'b0, 6'd0};
    vecs[5]  = '{25, 1'b1, 1'b1, 1'b0, 8'd52, 1'b0, 6'd0};
    vecs[6]  = '{26, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 6'd0};
    vecs[7]  = '{27, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 6'd0};
    vecs[8]  = '{28, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 6'd0};
    vecs[9]  = '{29, 1'b1, 1'b1, 1'b1, 8'd1,  1'b0, 6'd0};
    vecs[10] = '{56, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 6'd1};
    vecs[11] = '{57, 1'b1, 1'b1, 1'b1, 8'd2,  1'b0, 6'd0};

    n_reset = 1'b0; go = 1'b0; fm_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(get_obs()), 32'd0);
    sample();
    advance();
    n_reset = 1'b1;

    // Pass A: no stalls, table for the first pixels, then the whole pass.
    s0 = step_total; x0 = xfer_total; d0 = done_total;
    go = 1'b1; fm_valid = 1'b1; out_ready = 1'b1;
    sample();
    advance();
    go = 1'b0;
    tcyc = 1;
    for (int i = 0; i < 12; i++) begin
      while (tcyc < vecs[i].cyc) begin
        sample();
        advance();
      end
      sample();
      chk($sformatf("table_cyc%0d", vecs[i].cyc),
          32'({kern_start, kern_ready, acc_clr, (kern_start ? fm_rd_addr : 8'd0),
               out_valid, (out_valid ? out_addr : 6'd0)}),
          32'({vecs[i].ks, vecs[i].kr, vecs[i].clr, (vecs[i].ks ? vecs[i].addr : 8'd0),
               vecs[i].ov, (vecs[i].ov ? vecs[i].oa : 6'd0)}));
      advance();
    end

    seen = 0; done_at = 0;
    for (int i = 0; i < 2100 && !seen; i++) begin
      go = (tcyc == 100);
      sample();
      if (done) begin
        seen = 1;
        done_at = tcyc;
        go = 1'b1;
      end
      advance();
    end
    go = 1'b0;
    chk("passA_done_seen", 32'(seen), 32'd1);
    chk("passA_done_cycle", 32'(done_at), 32'd1793);
    chk("passA_transfers", 32'(xfer_total - x0), 32'(NPIX));
    chk("passA_steps", 32'(step_total - s0), 32'(NPIX * C2_TAPS));
    chk("passA_final_tap_addr", 32'(last_step_addr), 32'd143);
    chk("passA_done_pulses", 32'(done_total - d0), 32'd1);
    sample();
    chk("busy_falls_after_done", 32'(busy), 32'd0);
    advance();
    sample();
    chk("go_in_done_ignored", 32'(busy), 32'd0);
    advance();

    // Pass B: feature-map stall at tap 10 of pixel 0.
    s0 = step_total;
    go = 1'b1; fm_valid = 1'b1; out_ready = 1'b1;
    sample();
    advance();
    go = 1'b0;
    tcyc = 1;
    ov_at = 0;
    for (int i = 0; i < 60 && ov_at == 0; i++) begin
      fm_valid = !(tcyc >= 11 && tcyc <= 13);
      sample();
      if (!fm_valid)
        chk("stall_hold", 32'({kern_ready, acc_en, fm_rd_addr}), 32'({1'b0, 1'b0, 8'd24}));
      if (out_valid) begin
        ov_at = tcyc;
        chk("stall_tap_count", 32'(step_total - s0), 32'(C2_TAPS));
      end
      advance();
    end
    fm_valid = 1'b1;
    chk("stall_pixel_cycles", 32'(ov_at), 32'd31);

    // Output backpressure on pixel 9.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      out_ready = 1'b0;
      sample();
      if (out_valid && out_addr == 6'd9) found = 1;
      else begin
        if (out_valid) out_ready = 1'b1;
        advance();
      end
    end
    chk("pix9_emit_reached", 32'(found), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) sample();
      chk("pix9_held", 32'({out_valid, out_addr}), 32'({1'b1, 6'd9}));
      advance();
    end
    out_ready = 1'b1;
    sample();
    chk("pix9_accept", 32'({out_valid, out_addr}), 32'({1'b1, 6'd9}));
    advance();
    sample();
    chk("pix10_tap0", 32'({kern_ready, acc_clr, fm_rd_addr}),
        32'({1'b1, 1'b1, 8'((10 / C2_OUT_W) * C2_IN_W + 10 % C2_OUT_W)}));
    advance();

    // Rest of pass B under random stimulus, then go held through DONE.
    seen = 0;
    for (int i = 0; i < 8000 && !seen; i++) begin
      fm_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      go        = $urandom_range(0, 7) == 0;
      sample();
      if (done) begin
        seen = 1;
        go = 1'b1;
      end
      advance();
    end
    chk("passB_done_seen", 32'(seen), 32'd1);
    sample();
    chk("goheld_idle_gap", 32'(busy), 32'd0);
    advance();
    fm_valid = 1'b1;
    sample();
    chk("goheld_restart_tap0", 32'({kern_start, acc_clr, fm_rd_addr}), 32'({1'b1, 1'b1, 8'd0}));
    go = 1'b0;
    advance();

    // Pass C: random until pixel 20 tap 13, then reset mid-pixel.
    hit = 0;
    for (int i = 0; i < 8000 && !hit; i++) begin
      fm_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      sample();
      if (m_busy && !m_done && m_emit == 20 && m_steps == 20 * C2_TAPS + 13) hit = 1;
      else advance();
    end
    chk("reset_point_reached", 32'(hit), 32'd1);
    n_reset = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(get_obs()), 32'd0);
    advance();
    sample();
    advance();
    n_reset = 1'b1;
    go = 1'b1;
    sample();
    advance();
    go = 1'b0;
    fm_valid = 1'b1;
    sample();
    chk("post_reset_tap0", 32'({kern_start, acc_clr, fm_rd_addr, out_addr}),
        32'({1'b1, 1'b1, 8'd0, 6'd0}));
    advance();

    seen = 0;
    for (int i = 0; i < 8000 && !seen; i++) begin
      fm_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      sample();
      if (done) seen = 1;
      advance();
    end
    chk("passC_done_seen", 32'(seen), 32'd1);
    repeat (2) begin
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
